mux_16x1: RTL and testbench

- 16-to-1 selector. Chooses one of 16 WIDTH-bit inputs by a 4-bit address.
- Built as a 4-level tree of 15 mux2_1 cells.
- Provides a combinational output and a registered copy.
- Building block for wider selectors: two instances plus one mux2_1 form a 32:1 mux used in register-file read ports.

---
 rtl/mux_pkg.sv | 14 +
 rtl/mux2_1.sv | 19 +
 rtl/mux_16x1.sv | 91 +++++++++
 tb/tb_mux_16x1.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the 16:1 selector tree and a helper that locates each
// tree level inside the flat node array.
package mux_pkg;

  localparam int NUM_INPUTS = 16;
  localparam int SEL_W      = 4;
  localparam int LEVELS     = 4;

  // Nodes are stored leaves first, then each reduced level: bases 0,16,24,28,30.
  function automatic int level_base(input int lv);
    return (2 * NUM_INPUTS) - ((2 * NUM_INPUTS) >> lv);
  endfunction

endpackage

// File: rtl/mux2_1.sv
// Single-bit 2:1 selector cell; the 16:1 tree replicates it per bit and per node.
module mux2_1 (
  output logic out,
  input  logic i0,
  input  logic i1,
  input  logic sel
);

  // A known sel picks one leg only, so X on the other leg never reaches out.
  always_comb begin
    out = 1'b0;
    if (sel) begin
      out = i1;
    end else begin
      out = i0;
    end
  end

endmodule

// File: rtl/mux_16x1.sv
// 16:1 WIDTH-bit selector built as a 4-level mux2_1 tree with a registered copy.
// Optional macro MUX16_VALID_EN adds in_valid/out_valid gating of the register.
module mux_16x1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SEL_W-1:0]            addr,
  input  logic [NUM_INPUTS*WIDTH-1:0] muxIns,
`ifdef MUX16_VALID_EN
  input  logic                        in_valid,
  output logic                        out_valid,
`endif
  output logic [WIDTH-1:0]            out,
  output logic [WIDTH-1:0]            out_q
);

  logic [2*NUM_INPUTS-2:0][WIDTH-1:0] tree_node;
  logic [WIDTH-1:0]                   data_d;
  logic [WIDTH-1:0]                   data_q;

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_leaf
    assign tree_node[k] = muxIns[k*WIDTH +: WIDTH];
  end

  // Level lv reduces pairs from its input level using addr[lv] as the select.
  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_level
    localparam int IN_BASE  = level_base(lv);
    localparam int OUT_BASE = level_base(lv + 1);
    for (genvar j = 0; j < (NUM_INPUTS >> (lv + 1)); j++) begin : g_node
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        mux2_1 u_cell (
          .out (tree_node[OUT_BASE + j][b]),
          .i0  (tree_node[IN_BASE + 2*j][b]),
          .i1  (tree_node[IN_BASE + 2*j + 1][b]),
          .sel (addr[lv])
        );
      end
    end
  end

  assign out = tree_node[2*NUM_INPUTS-2];

`ifdef MUX16_VALID_EN
  logic valid_d;
  logic valid_q;

  // Capture the selected value only on qualified edges; valid tracks every edge.
  always_comb begin
    data_d  = data_q;
    valid_d = in_valid;
    if (in_valid) begin
      data_d = out;
    end else begin
      data_d = data_q;
    end
  end

  // Output register with synchronous reset taking priority over any load.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
`else
  // Without qualification the register loads the selected value every edge.
  always_comb begin
    data_d = out;
  end

  // Output register with synchronous reset taking priority over any load.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= {WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end
`endif

  assign out_q = data_q;

endmodule

// File: tb/tb_mux_16x1.sv
// Scoreboard bench for mux_16x1 (WIDTH=8): the driver pushes reference results,
// a monitor pops and compares them after every rising edge.
module tb_mux_16x1;

  localparam int W = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      addr;
  logic [16*W-1:0] muxIns;
  logic [W-1:0]    out;
  logic [W-1:0]    out_q;
`ifdef MUX16_VALID_EN
  logic            in_valid;
  logic            out_valid;
`endif

  always #5 clk = ~clk;

  mux_16x1 #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .muxIns   (muxIns),
`ifdef MUX16_VALID_EN
    .in_valid (in_valid),
    .out_valid(out_valid),
`endif
    .out      (out),
    .out_q    (out_q)
  );

  typedef struct packed {
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_q;
    logic         exp_v;
  } exp_t;

  exp_t         exp_queue[$];
  exp_t         mon_e;
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] data [16];
  logic [W-1:0] model_q = '0;
  logic         model_v = 1'b0;

  // Reference: a plain array lookup and a one-deep register with reset/valid rules.
  task automatic apply(input logic r, input logic v, input logic [3:0] a);
    exp_t e;
    @(negedge clk);
    reset = r;
    addr  = a;
`ifdef MUX16_VALID_EN
    in_valid = v;
`endif
    for (int k = 0; k < 16; k++) muxIns[k*W +: W] = data[k];
    e.exp_out = data[a];
    if (r) begin
      model_q = '0;
      model_v = 1'b0;
    end else begin
      if (v) model_q = data[a];
      model_v = v;
    end
    e.exp_q = model_q;
    e.exp_v = model_v;
    exp_queue.push_back(e);
  endtask

  task automatic rand_data();
    for (int k = 0; k < 16; k++) data[k] = W'($urandom);
  endtask

  // Monitor: one scoreboard entry is retired after each rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_queue.size() > 0) begin
      mon_e = exp_queue.pop_front();
      n_vec++;
      if (out !== mon_e.exp_out) begin
        n_err++;
        $display("FAIL comb_out addr=%0d got %h want %h", addr, out, mon_e.exp_out);
      end
      n_vec++;
      if (out_q !== mon_e.exp_q) begin
        n_err++;
        $display("FAIL reg_out_q got %h want %h", out_q, mon_e.exp_q);
      end
`ifdef MUX16_VALID_EN
      n_vec++;
      if (out_valid !== mon_e.exp_v) begin
        n_err++;
        $display("FAIL out_valid got %b want %b", out_valid, mon_e.exp_v);
      end
`endif
    end
  end

  initial begin
    logic [15:0] pat;
    logic        v;
    reset  = 1'b1;
    addr   = 4'd0;
    muxIns = '0;
`ifdef MUX16_VALID_EN
    in_valid = 1'b0;
`endif

    // Two reset cycles with arbitrary data.
    for (int i = 0; i < 2; i++) begin
      rand_data();
      apply(1'b1, 1'b1, 4'($urandom));
    end

    // Registered path with pattern A5C3: input k carries bit k.
    pat = 16'hA5C3;
    for (int k = 0; k < 16; k++) data[k] = {{(W-1){1'b0}}, pat[k]};
    apply(1'b0, 1'b1, 4'd5);
    apply(1'b0, 1'b1, 4'd0);
    apply(1'b1, 1'b1, 4'd0);
    apply(1'b0, 1'b1, 4'd0);

    // Input k = k*17: addr 15 selects FF, addr 3 selects 33.
    for (int k = 0; k < 16; k++) data[k] = W'(k * 17);
    apply(1'b0, 1'b1, 4'd15);
    apply(1'b0, 1'b1, 4'd3);

    // Walking one at each position, then probed from a random address.
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) data[j] = (j == k) ? W'(1) : W'(0);
      apply(1'b0, 1'b1, 4'(k));
      apply(1'b0, 1'b1, 4'($urandom));
    end

    // Random traffic with sporadic reset and, when present, random valid.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) rand_data();
`ifdef MUX16_VALID_EN
      v = 1'($urandom);
`else
      v = 1'b1;
`endif
      apply(($urandom_range(0, 15) == 0), v, 4'($urandom));
    end

    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_queue.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d left want 0", exp_queue.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
